// File: rtl/vdb_seg7_decimal_driver.sv
// Binary-to-decimal 7-segment driver: handshake-accepted value, serial double-dabble
// conversion, then one registered update of all digit segment vectors.
module vdb_seg7_decimal_driver #(
  parameter int DIGITS = 4,
  parameter int WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  output logic                  ready,
  input  logic [WIDTH-1:0]      value,
  input  logic [DIGITS-1:0]     dp,
  input  logic                  blank_leading,
  output logic [DIGITS*8-1:0]   seg,
  output logic                  done,
  output logic                  overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] LP_LIMIT = pow10(DIGITS);

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'h3F;
      4'd1:    seg7 = 8'h06;
      4'd2:    seg7 = 8'h5B;
      4'd3:    seg7 = 8'h4F;
      4'd4:    seg7 = 8'h66;
      4'd5:    seg7 = 8'h6D;
      4'd6:    seg7 = 8'h7D;
      4'd7:    seg7 = 8'h07;
      4'd8:    seg7 = 8'h7F;
      4'd9:    seg7 = 8'h6F;
      default: seg7 = 8'h00;
    endcase
  endfunction

  typedef enum logic [1:0] {IDLE, CONV, UPDATE} state_t;

  state_t                r_state;
  state_t                w_stateNext;
  logic [CW-1:0]         r_cnt;
  logic [WIDTH-1:0]      r_bin;
  logic [DIGITS*4-1:0]   r_bcd;
  logic [DIGITS-1:0]     r_dp;
  logic                  r_blank;
  logic                  r_ovfPending;
  logic                  w_accept;
  logic                  w_lastIter;
  logic [DIGITS*4-1:0]   w_bcdAdj;
  logic [DIGITS*4+WIDTH-1:0] w_shift;
  logic [DIGITS*8-1:0]   w_segNext;

  assign ready      = (r_state == IDLE) && !rst;
  assign w_accept   = valid && ready;
  assign w_lastIter = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_stateNext = CONV;
      CONV:    if (w_lastIter) w_stateNext = UPDATE;
      UPDATE:  w_stateNext = IDLE;
      default: w_stateNext = IDLE;
    endcase
  end

  // Shift-add-3: correct every nibble that would exceed 9 after doubling, then shift.
  always_comb begin
    w_bcdAdj = r_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_bcdAdj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
    w_shift = {w_bcdAdj, r_bin} << 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_bin        <= '0;
      r_bcd        <= '0;
      r_dp         <= '0;
      r_blank      <= 1'b0;
      r_ovfPending <= 1'b0;
    end else if (w_accept) begin
      r_cnt        <= '0;
      r_bin        <= value;
      r_bcd        <= '0;
      r_dp         <= dp;
      r_blank      <= blank_leading;
      r_ovfPending <= (64'(value) >= LP_LIMIT);
    end else if (r_state == CONV) begin
      {r_bcd, r_bin} <= w_shift;
      r_cnt          <= w_lastIter ? '0 : r_cnt + 1'b1;
    end
  end

  // Scan from the most significant digit so the zero run tells which digits are leading.
  always_comb begin
    logic [3:0] w_nib;
    logic       w_zeroRun;
    w_segNext = '0;
    w_zeroRun = 1'b1;
    w_nib     = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_nib     = r_bcd[i*4 +: 4];
      w_zeroRun = w_zeroRun && (w_nib == 4'd0);
      if (r_ovfPending)
        w_segNext[i*8 +: 8] = 8'h40;
      else if (r_blank && (i > 0) && w_zeroRun)
        w_segNext[i*8 +: 8] = {r_dp[i], 7'b0};
      else
        w_segNext[i*8 +: 8] = seg7(w_nib) | {r_dp[i], 7'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg      <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (r_state == UPDATE) begin
        seg      <= w_segNext;
        overflow <= r_ovfPending;
        done     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vdb_seg7_decimal_driver.sv
// Self-checking bench for vdb_seg7_decimal_driver: directed vector table, random values
// against a decimal-arithmetic model, and handshake/reset corner sequences.
module tb_vdb_seg7_decimal_driver;

  localparam int DIGITS = 4;
  localparam int WIDTH  = 14;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        ready;
  logic [13:0] value;
  logic [3:0]  dp;
  logic        blank_leading;
  logic [31:0] seg;
  logic        done;
  logic        overflow;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  vdb_seg7_decimal_driver #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .valid(valid), .ready(ready), .value(value), .dp(dp),
    .blank_leading(blank_leading), .seg(seg), .done(done), .overflow(overflow)
  );

  typedef struct {
    logic [13:0] v;
    logic [3:0]  d;
    logic        b;
    logic [31:0] s;
    logic        o;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Reference: split the value into decimal digits arithmetically, blank above the top nonzero digit.
  function automatic logic [31:0] modelSeg(input int unsigned v, input logic [3:0] d, input logic b);
    logic [7:0]  codes [10];
    logic [31:0] r;
    int          lead;
    int          dig;
    logic [7:0]  s;
    codes = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};
    r = '0;
    lead = 0;
    if (v >= 10000) return 32'h40404040;
    for (int i = 0; i < 4; i++) if (((v / (10 ** i)) % 10) != 0) lead = i;
    for (int i = 0; i < 4; i++) begin
      dig = int'((v / (10 ** i)) % 10);
      s = (b && i > lead) ? 8'h00 : codes[dig];
      if (d[i]) s = s | 8'h80;
      r[i*8 +: 8] = s;
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic [13:0] v, input logic [3:0] d, input logic b, input int noise,
                               output logic [31:0] segOut, output logic ovfOut, output int lat,
                               output logic readyAtDone, output logic readyMid);
    int w;
    w = 0;
    @(negedge clk);
    while (!ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    checkOutput("ready wait", 32'(w < 50), 32'd1);
    value = v; dp = d; blank_leading = b; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    value = 14'($urandom); dp = 4'($urandom); blank_leading = 1'($urandom);
    readyMid = ready;
    lat = 0;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (!done && lat < 2 * noise) begin
        valid = ~valid;
        value = 14'($urandom);
      end else begin
        valid = 1'b0;
      end
    end
    segOut = seg;
    ovfOut = overflow;
    readyAtDone = ready;
  endtask

  task automatic runVector(input string name, input logic [13:0] v, input logic [3:0] d, input logic b,
                           input logic [31:0] expSeg, input logic expOvf, input int noise);
    logic [31:0] s;
    logic        o, rd, rm;
    int          lat;
    applyStimulus(v, d, b, noise, s, o, lat, rd, rm);
    checkOutput({name, " seg"}, s, expSeg);
    checkOutput({name, " overflow"}, 32'(o), 32'(expOvf));
    checkOutput({name, " latency"}, 32'(lat), 32'd15);
    checkOutput({name, " ready at done"}, 32'(rd), 32'd1);
    checkOutput({name, " ready during conv"}, 32'(rm), 32'd0);
    @(negedge clk);
    checkOutput({name, " done one pulse"}, 32'(done), 32'd0);
    checkOutput({name, " seg held"}, seg, expSeg);
  endtask

  initial begin
    logic [13:0] rv;
    logic [3:0]  rd;
    logic        rb;
    int          q[$];
    int          acceptCyc[$];
    int          cyc, results, nDone, nReadyLow;

    rst = 1'b1; valid = 1'b0; value = '0; dp = '0; blank_leading = 1'b0;

    vecs.push_back('{14'd1234,  4'b0000, 1'b0, 32'h065B4F66, 1'b0});
    vecs.push_back('{14'd7,     4'b0000, 1'b1, 32'h00000007, 1'b0});
    vecs.push_back('{14'd0,     4'b0000, 1'b1, 32'h0000003F, 1'b0});
    vecs.push_back('{14'd0,     4'b0000, 1'b0, 32'h3F3F3F3F, 1'b0});
    vecs.push_back('{14'd10000, 4'b0000, 1'b0, 32'h40404040, 1'b1});
    vecs.push_back('{14'd16383, 4'b1111, 1'b1, 32'h40404040, 1'b1});
    vecs.push_back('{14'd9999,  4'b0000, 1'b0, 32'h6F6F6F6F, 1'b0});
    vecs.push_back('{14'd5,     4'b0010, 1'b1, 32'h0000806D, 1'b0});
    vecs.push_back('{14'd100,   4'b0000, 1'b1, 32'h00063F3F, 1'b0});
    vecs.push_back('{14'd5,     4'b1000, 1'b1, 32'h8000006D, 1'b0});
    vecs.push_back('{14'd9,     4'b0001, 1'b0, 32'h3F3F3FEF, 1'b0});

    repeat (3) @(negedge clk);
    checkOutput("reset ready", 32'(ready), 32'd0);
    checkOutput("reset seg", seg, 32'h0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("ready after reset", 32'(ready), 32'd1);

    foreach (vecs[i])
      runVector($sformatf("vec%0d", i), vecs[i].v, vecs[i].d, vecs[i].b, vecs[i].s, vecs[i].o, 0);

    runVector("noisy valid", 14'd1234, 4'b0000, 1'b0, 32'h065B4F66, 1'b0, 5);

    for (int i = 0; i < 30; i++) begin
      rv = (i % 3 == 0) ? 14'($urandom_range(0, 16383)) : 14'($urandom_range(0, 9999));
      rd = 4'($urandom);
      rb = 1'($urandom);
      runVector($sformatf("rand%0d v=%0d", i, rv), rv, rd, rb, modelSeg(rv, rd, rb), rv >= 14'd10000, 0);
    end

    // valid held high: accepts must land exactly on done cycles, one every WIDTH+2 cycles
    cyc = 0; results = 0;
    @(negedge clk);
    dp = '0; blank_leading = 1'b0;
    value = 14'($urandom_range(0, 16383));
    valid = 1'b1;
    while (results < 5 && cyc < 200) begin
      if (ready) begin
        q.push_back(int'(value));
        acceptCyc.push_back(cyc);
      end
      @(negedge clk);
      cyc++;
      if (done) begin
        rv = (q.size() > 0) ? 14'(q.pop_front()) : 14'd0;
        checkOutput($sformatf("b2b seg v=%0d", rv), seg, modelSeg(rv, 4'b0000, 1'b0));
        checkOutput("b2b overflow", 32'(overflow), 32'(rv >= 14'd10000));
        results++;
      end
      if (results == 5) valid = 1'b0;
      else value = 14'($urandom_range(0, 16383));
    end
    valid = 1'b0;
    checkOutput("b2b results", 32'(results), 32'd5);
    checkOutput("b2b queue empty", 32'(q.size()), 32'd0);
    for (int k = 1; k < acceptCyc.size(); k++)
      checkOutput($sformatf("b2b interval %0d", k), 32'(acceptCyc[k] - acceptCyc[k-1]), 32'd16);

    // reset partway through converting 4321, with valid also asserted during reset
    repeat (2) @(negedge clk);
    value = 14'd4321; dp = '0; blank_leading = 1'b0; valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1; valid = 1'b1; value = 14'd1234;
    @(negedge clk);
    checkOutput("midreset ready", 32'(ready), 32'd0);
    checkOutput("midreset seg", seg, 32'h0);
    checkOutput("midreset done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0; valid = 1'b0;
    #1;
    checkOutput("ready after midreset", 32'(ready), 32'd1);
    nDone = 0; nReadyLow = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) nDone++;
      if (!ready) nReadyLow++;
    end
    checkOutput("no done after abort", 32'(nDone), 32'd0);
    checkOutput("idle after reset+valid", 32'(nReadyLow), 32'd0);
    checkOutput("seg still clear", seg, 32'h0);
    runVector("after reset 42", 14'd42, 4'b0000, 1'b0, 32'h3F3F665B, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
